regfile_write_sequencer: RTL and testbench
==========================================

Name: regfile_write_sequencer

Overview:
- Write-side counterpart of the register file's read wordline decoder.
- Buffers register write-back requests (register ID + 16-bit data) in a small FIFO.
- Retires at most one request per cycle by driving a one-hot write wordline and the write data into the 16x16 register array.
- Gives the read path a forwarding lookup of writes that are still pending.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two, 2..8.
- DROP_R0, 1, when 1 a write to register 0 is accepted but discarded (R0 is hardwired zero); when 0 it is buffered like any other write.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  write request valid.
- in_ready  output  1  sequencer can accept a request this cycle.
- in_reg  input  4  destination register ID.
- in_data  input  16  write data.
- wr_stall  input  1  register array busy; blocks retirement this cycle.
- flush  input  1  synchronous discard of all pending writes.
- Wordline  output  16  one-hot write enable into the array; all zero when no write.
- WriteData  output  16  data for the asserted wordline.
- query_reg  input  4  register ID probed by the read path.
- query_hit  output  1  a pending write to query_reg exists.
- query_data  output  16  data of the youngest pending write to query_reg.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, rst_n low):
  - Pointers and count clear to 0; in_ready=1 once rst_n is high.
  - Wordline=0, WriteData=0, query_hit=0, query_data=0, occupancy=0.
- Accept:
  - push = in_valid & in_ready.
  - in_ready = (count < DEPTH) & ~flush.
  - At full, no push is taken even if a pop happens in the same cycle.
- Drop: if DROP_R0=1 and in_reg=0, push completes the handshake but writes no entry and count is unchanged.
- Retire:
  - pop = (count != 0) & ~wr_stall & ~flush.
  - When pop is 1: Wordline = 1 << head.reg and WriteData = head.data, both combinational from head storage. Otherwise Wordline=0 and WriteData=0.
  - The array captures the write on the same rising edge that pops the entry.
- Latency: an entry pushed at edge N can drive Wordline no earlier than the cycle after edge N. There is no same-cycle bypass from in_* to Wordline.
- Ordering: strict FIFO. Two writes to the same register retire in arrival order.
- Simultaneous push and pop (not full): count unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- wr_stall: holds head, count, and pointers. Wordline is 0 while stalled. A push may still occur while stalled.
- flush:
  - Takes priority over push and pop.
  - Count and pointers clear at the next edge; Wordline=0 that cycle.
  - A flush coinciding with in_valid does not accept the request, since in_ready=0.
- Forwarding (combinational):
  - Compare query_reg against all valid entries, including the head being popped this cycle.
  - On multiple matches, the youngest entry supplies query_data.
  - No match: query_hit=0, query_data=0.
  - A request being pushed in the same cycle is not visible to the lookup.
  - query_reg=0 with DROP_R0=1 always gives hit=0.
- occupancy equals count at all times.
- Reset mid-operation: all pending writes are lost and no wordline pulses after reset assertion.

Test Plan:
- Reset, then push (reg 5, 0xBEEF) at edge 1 -> the cycle after edge 1 shows Wordline=0x0020, WriteData=0xBEEF; occupancy 1 -> 0 after edge 2.
- Hold wr_stall=1 and push 5 writes (DEPTH=4) to regs 1,2,3,4,6 -> in_ready=0 after the 4th; 5th held. Release stall -> Wordlines 0x0002, 0x0004, 0x0008, 0x0010, then 0x0040 on consecutive cycles.
- Push (reg 7, 0x1111) then (reg 7, 0x2222) under stall; query_reg=7 -> hit=1, data=0x2222. After both retire -> hit=0, data=0.
- DROP_R0=1, push (reg 0, 0xFFFF) -> handshake completes, occupancy stays 0, Wordline never 0x0001. With DROP_R0=0 -> Wordline=0x0001 once.
- Three entries pending, assert flush together with in_valid -> next cycle occupancy=0, Wordline=0, request not accepted. Assert rst_n=0 mid-stream -> outputs 0 immediately.
- Full FIFO with pop and in_valid in the same cycle -> no push, occupancy 3. Pointer wrap verified over 20 random push/pop cycles against a reference model.

Source files
------------

// File: rtl/regfile_write_sequencer.sv
// Write-back sequencer for the 16x16 register array: FIFO-buffers writes, retires one per
// cycle as a one-hot wordline, and forwards pending write data to the read path.
module regfile_write_sequencer #(
   parameter int DEPTH   = 4,
   parameter bit DROP_R0 = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_reg,
   input  logic [15:0]              in_data,
   input  logic                     wr_stall,
   input  logic                     flush,
   output logic [15:0]              Wordline,
   output logic [15:0]              WriteData,
   input  logic [3:0]               query_reg,
   output logic                     query_hit,
   output logic [15:0]              query_data,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [3:0]    reg_mem  [DEPTH];
   logic [15:0]   data_mem [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic push, pop, drop, store;

   assign in_ready = (count_q < CW'(DEPTH)) & ~flush;
   assign push     = in_valid & in_ready;
   assign drop     = DROP_R0 && (in_reg == 4'd0);
   assign store    = push & ~drop;
   assign pop      = (count_q != '0) & ~wr_stall & ~flush;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (store) tail_d = tail_q + PW'(1);
         if (pop)   head_d = head_q + PW'(1);
         count_d = count_q + CW'(store) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset: validity comes entirely from head/count.
   always_ff @(posedge clk) begin
      if (store) begin
         reg_mem[tail_q]  <= in_reg;
         data_mem[tail_q] <= in_data;
      end
   end

   assign Wordline  = pop ? (16'h0001 << reg_mem[head_q]) : 16'h0000;
   assign WriteData = pop ? data_mem[head_q] : 16'h0000;
   assign occupancy = count_q;

   // Slot gi holds the entry of age offset gi from the head; larger offset is younger.
   logic [PW-1:0] slot  [DEPTH];
   logic [DEPTH-1:0] match;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
         assign slot[gi]  = head_q + PW'(gi);
         assign match[gi] = (CW'(gi) < count_q) &&
                            (reg_mem[slot[gi]] == query_reg) &&
                            !(DROP_R0 && (query_reg == 4'd0));
      end
   endgenerate

   always_comb begin
      query_hit  = 1'b0;
      query_data = 16'h0000;
      for (int k = 0; k < DEPTH; k++) begin
         if (match[k]) begin
            query_hit  = 1'b1;
            query_data = data_mem[slot[k]];
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench for regfile_write_sequencer: driver queues expected retirements,
// a negedge monitor pops them whenever a wordline fires.
module tb_regfile_write_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_reg;
   logic [15:0] in_data;
   logic        wr_stall;
   logic        flush;
   logic [15:0] Wordline;
   logic [15:0] WriteData;
   logic [3:0]  query_reg;
   logic        query_hit;
   logic [15:0] query_data;
   logic [2:0]  occupancy;

   logic        in_ready_b;
   logic [15:0] wl_b, wd_b;
   logic        hit_b;
   logic [15:0] qd_b;
   logic [2:0]  occ_b;

   int errors = 0;
   int checks = 0;
   int b_r0   = 0;

   typedef struct {
      logic [3:0]  r;
      logic [15:0] d;
   } ent_t;

   ent_t sb[$];
   ent_t mon_e;

   always #5 clk = ~clk;

   regfile_write_sequencer #(.DEPTH(4), .DROP_R0(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg(in_reg), .in_data(in_data), .wr_stall(wr_stall), .flush(flush),
      .Wordline(Wordline), .WriteData(WriteData), .query_reg(query_reg),
      .query_hit(query_hit), .query_data(query_data), .occupancy(occupancy)
   );

   regfile_write_sequencer #(.DEPTH(4), .DROP_R0(1'b0)) dut_keep_r0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_reg(in_reg), .in_data(in_data), .wr_stall(wr_stall), .flush(flush),
      .Wordline(wl_b), .WriteData(wd_b), .query_reg(query_reg),
      .query_hit(hit_b), .query_data(qd_b), .occupancy(occ_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus plus the hand-computed expectations for that cycle.
   task automatic cyc(input logic v, input logic [3:0] r, input logic [15:0] d,
                      input logic st, input logic fl, input logic [3:0] q,
                      input logic er, input int eo, input logic eh,
                      input logic [15:0] eqd, input bit chkq);
      ent_t e;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_reg    = r;
      in_data   = d;
      wr_stall  = st;
      flush     = fl;
      query_reg = q;
      if (fl) sb.delete();
      if (v && er && (r != 4'd0)) begin
         e.r = r;
         e.d = d;
         sb.push_back(e);
      end
      @(negedge clk);
      chk("in_ready", in_ready, er);
      chk("occupancy", occupancy, eo);
      if (chkq) begin
         chk("query_hit", query_hit, eh);
         chk("query_data", query_data, eqd);
      end
   endtask

   always @(negedge clk) begin
      if (Wordline != 16'h0000) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wordline: got %h, expected none pending", Wordline);
         end else begin
            mon_e = sb.pop_front();
            $display("retire wordline=%h data=%h", Wordline, WriteData);
            chk("wordline", Wordline, 16'h0001 << mon_e.r);
            chk("writedata", WriteData, mon_e.d);
         end
      end else begin
         chk("writedata_idle", WriteData, 16'h0000);
      end
      if (wl_b == 16'h0001) begin
         b_r0++;
         $display("retire r0 (keep) data=%h", wd_b);
         chk("r0_keep_data", wd_b, 16'hFFFF);
      end
   end

   initial begin
      logic        v, st, er;
      logic [3:0]  r;
      logic [15:0] d;
      int          mcnt;

      rst_n = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
      wr_stall = 1'b0; flush = 1'b0; query_reg = 4'd5;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #2;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_wordline", Wordline, 16'h0000);
      chk("rst_writedata", WriteData, 16'h0000);
      chk("rst_query_hit", query_hit, 1'b0);
      chk("rst_query_data", query_data, 16'h0000);

      // Single push, one-cycle latency to the wordline.
      cyc(1, 4'd5, 16'hBEEF, 0, 0, 4'd5, 1, 0, 0, 16'h0000, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd5, 1, 1, 1, 16'hBEEF, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd5, 1, 0, 0, 16'h0000, 1);

      // Fill under stall, fifth request waits, full-with-pop takes no push.
      cyc(1, 4'd1, 16'h1001, 1, 0, 4'd3, 1, 0, 0, 16'h0000, 1);
      cyc(1, 4'd2, 16'h1002, 1, 0, 4'd3, 1, 1, 0, 16'h0000, 1);
      cyc(1, 4'd3, 16'h1003, 1, 0, 4'd3, 1, 2, 0, 16'h0000, 1);
      cyc(1, 4'd4, 16'h1004, 1, 0, 4'd3, 1, 3, 1, 16'h1003, 1);
      cyc(1, 4'd6, 16'h1006, 1, 0, 4'd3, 0, 4, 1, 16'h1003, 1);
      cyc(1, 4'd6, 16'h1006, 0, 0, 4'd3, 0, 4, 1, 16'h1003, 1);
      cyc(1, 4'd6, 16'h1006, 0, 0, 4'd3, 1, 3, 1, 16'h1003, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd3, 1, 3, 1, 16'h1003, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd3, 1, 2, 0, 16'h0000, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd3, 1, 1, 0, 16'h0000, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd3, 1, 0, 0, 16'h0000, 1);

      // Same register twice: youngest forwards, order preserved on retire.
      cyc(1, 4'd7, 16'h1111, 1, 0, 4'd7, 1, 0, 0, 16'h0000, 1);
      cyc(1, 4'd7, 16'h2222, 1, 0, 4'd7, 1, 1, 1, 16'h1111, 1);
      cyc(0, 4'd0, 16'h0000, 1, 0, 4'd7, 1, 2, 1, 16'h2222, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd7, 1, 2, 1, 16'h2222, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd7, 1, 1, 1, 16'h2222, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd7, 1, 0, 0, 16'h0000, 1);

      // Register 0: dropped by the default instance, retired once by the other.
      cyc(1, 4'd0, 16'hFFFF, 0, 0, 4'd0, 1, 0, 0, 16'h0000, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd0, 1, 0, 0, 16'h0000, 1);
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd0, 1, 0, 0, 16'h0000, 1);

      // Flush with in_valid: request refused, everything discarded.
      cyc(1, 4'd8,  16'h3008, 1, 0, 4'd9, 1, 0, 0, 16'h0000, 1);
      cyc(1, 4'd9,  16'h3009, 1, 0, 4'd9, 1, 1, 0, 16'h0000, 1);
      cyc(1, 4'd10, 16'h300A, 1, 0, 4'd9, 1, 2, 1, 16'h3009, 1);
      cyc(1, 4'd11, 16'h300B, 0, 1, 4'd9, 0, 3, 1, 16'h3009, 1);
      cyc(0, 4'd0,  16'h0000, 0, 0, 4'd9, 1, 0, 0, 16'h0000, 1);

      // Reset asserted with writes pending and the stall released at the same moment.
      cyc(1, 4'd12, 16'h400C, 1, 0, 4'd12, 1, 0, 0, 16'h0000, 1);
      cyc(1, 4'd13, 16'h400D, 1, 0, 4'd12, 1, 1, 1, 16'h400C, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; wr_stall = 1'b0; rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_wordline", Wordline, 16'h0000);
      chk("midrst_occupancy", occupancy, 0);
      chk("midrst_query_hit", query_hit, 1'b0);
      chk("midrst_query_data", query_data, 16'h0000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(0, 4'd0, 16'h0000, 0, 0, 4'd12, 1, 0, 0, 16'h0000, 1);

      // Pseudo-random push/stall mix to exercise pointer wrap and the full boundary.
      mcnt = 0;
      for (int i = 0; i < 20; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 2) == 0);
         r  = 4'($urandom_range(1, 15));
         d  = 16'($urandom_range(0, 65535));
         er = (mcnt < 4);
         cyc(v, r, d, st, 0, 4'd0, er, mcnt, 0, 16'h0000, 0);
         mcnt = mcnt + ((v && er) ? 1 : 0) - (((mcnt != 0) && !st) ? 1 : 0);
      end
      for (int i = 0; i < 6; i++) begin
         cyc(0, 4'd0, 16'h0000, 0, 0, 4'd0, 1, mcnt, 0, 16'h0000, 1);
         if (mcnt > 0) mcnt--;
      end

      @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      chk("r0_keep_pulses", b_r0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
